// File: rtl/pcie_cpl_tx_multi.sv
// rtl/pcie_cpl_tx_multi.sv - PCIe completion TLP generator for 1..P_MAX_LEN_DW dword memory reads
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   s_axis_tx_*                128-bit AXI-Stream TX towards the PCIe core
//   tx_src_dsc                 source discontinue, never used (tied 0)
//   req_*                      latched request from the RX decoder, sampled in IDLE
//   completer_id               our own bus/dev/func
//   rd_en/rd_addr/rd_be        payload read strobe, DW-aligned byte address, byte enables
//   rd_data                    payload read data, valid the cycle after rd_en
//   compl_done                 one-cycle pulse on the final beat handshake
module pcie_cpl_tx_multi #(
    parameter int P_DATA_WIDTH = 128,
    parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8,
    parameter int P_MAX_LEN_DW = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    s_axis_tx_tready,
    output logic [P_DATA_WIDTH-1:0] s_axis_tx_tdata,
    output logic [P_KEEP_WIDTH-1:0] s_axis_tx_tkeep,
    output logic                    s_axis_tx_tlast,
    output logic                    s_axis_tx_tvalid,
    output logic                    tx_src_dsc,
    input  logic                    req_compl,
    input  logic                    req_compl_wd,
    input  logic [2:0]              req_tc,
    input  logic                    req_td,
    input  logic                    req_ep,
    input  logic [1:0]              req_attr,
    input  logic [9:0]              req_len,
    input  logic [15:0]             req_rid,
    input  logic [7:0]              req_tag,
    input  logic [7:0]              req_be,
    input  logic [31:0]             req_addr,
    input  logic [15:0]             completer_id,
    output logic                    rd_en,
    output logic [31:0]             rd_addr,
    output logic [3:0]              rd_be,
    input  logic [31:0]             rd_data,
    output logic                    compl_done
);

    localparam logic [10:0] MAX_L = 11'(P_MAX_LEN_DW);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_FETCH, S_HDR_LOAD, S_FETCH, S_SEND, S_CPL
    } state_t;

    state_t state, state_nxt;

    // Per-request context needed after the header has been built
    logic [29:0]  base_dw;
    logic [3:0]   first_be, last_be;
    logic [10:0]  len_dw;
    logic [10:0]  idx;          // payload index of the next read
    logic [10:0]  remaining;    // payload DW not yet packed into a beat
    logic [2:0]   fcnt, fk;     // reads issued / reads wanted in this FETCH
    logic [1:0]   cap_slot;     // beat DW slot the in-flight read lands in
    logic         rd_pend;
    logic [127:0] beat_data;
    logic [15:0]  beat_keep;
    logic         beat_last;

    function automatic logic [2:0] tz4(input logic [3:0] b);
        casez (b)
            4'b???1: tz4 = 3'd0;
            4'b??10: tz4 = 3'd1;
            4'b?100: tz4 = 3'd2;
            4'b1000: tz4 = 3'd3;
            default: tz4 = 3'd4;
        endcase
    endfunction

    function automatic logic [2:0] lz4(input logic [3:0] b);
        casez (b)
            4'b1???: lz4 = 3'd0;
            4'b01??: lz4 = 3'd1;
            4'b001?: lz4 = 3'd2;
            4'b0001: lz4 = 3'd3;
            default: lz4 = 3'd4;
        endcase
    endfunction

    // Byte count of a single-DW access, from the span of its byte enables
    function automatic logic [11:0] bc_single(input logic [3:0] b);
        casez (b)
            4'b1??1:                     bc_single = 12'd4;
            4'b01?1, 4'b1?10:            bc_single = 12'd3;
            4'b0011, 4'b0110, 4'b1100:   bc_single = 12'd2;
            default:                     bc_single = 12'd1;
        endcase
    endfunction

    function automatic logic [15:0] keep_of(input logic [2:0] n);
        case (n)
            3'd1:    keep_of = 16'h000F;
            3'd2:    keep_of = 16'h00FF;
            3'd3:    keep_of = 16'h0FFF;
            default: keep_of = 16'hFFFF;
        endcase
    endfunction

    // Header fields derived straight from the request inputs (used in IDLE)
    logic [10:0] req_l;
    logic        req_ur;
    logic [12:0] bc_span;
    logic [11:0] bc_d, bc_c;
    logic [1:0]  lo_off;
    logic [31:0] dw0_d, dw0_c, dw1_d, dw1_c, dw2_d, dw2_c;
    logic [2:0]  chunk;

    always_comb begin
        req_l   = (req_len == 10'd0) ? 11'd1024 : {1'b0, req_len};
        req_ur  = req_compl_wd && (req_l > MAX_L);
        // 1024 DW gives 4096, which wraps to 0 in the 12-bit field
        bc_span = {req_l, 2'b00} - {10'd0, tz4(req_be[3:0])} - {10'd0, lz4(req_be[7:4])};
        bc_d    = (req_l == 11'd1) ? bc_single(req_be[3:0]) : bc_span[11:0];
        bc_c    = req_ur ? 12'd0 : bc_single(req_be[3:0]);
        lo_off  = (req_be[3:0] == 4'd0) ? 2'd0 : tz4(req_be[3:0])[1:0];
        dw0_d   = {1'b0, 7'b1001010, 1'b0, req_tc, 4'b0, req_td, req_ep, req_attr, 2'b0, req_len};
        dw0_c   = {1'b0, 7'b0001010, 1'b0, req_tc, 4'b0, req_td, req_ep, req_attr, 2'b0, 10'd0};
        dw1_d   = {completer_id, 3'b000, 1'b0, bc_d};
        dw1_c   = {completer_id, (req_ur ? 3'b001 : 3'b000), 1'b0, bc_c};
        dw2_d   = {req_rid, req_tag, 1'b0, req_addr[6:2], lo_off};
        dw2_c   = {req_rid, req_tag, 1'b0, 7'd0};
        chunk   = (remaining > 11'd4) ? 3'd4 : remaining[2:0];
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (req_compl) state_nxt = (req_compl_wd && !req_ur) ? S_HDR_FETCH : S_CPL;
            S_HDR_FETCH: state_nxt = S_HDR_LOAD;
            S_HDR_LOAD:  state_nxt = S_SEND;
            // fcnt reaches fk in the cycle the last read's data is captured
            S_FETCH:     if (fcnt == fk) state_nxt = S_SEND;
            S_SEND:      if (s_axis_tx_tready) state_nxt = (remaining != 11'd0) ? S_FETCH : S_IDLE;
            S_CPL:       if (s_axis_tx_tready) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Datapath: request context, read bookkeeping and beat assembly
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            base_dw   <= '0;
            first_be  <= '0;
            last_be   <= '0;
            len_dw    <= '0;
            idx       <= '0;
            remaining <= '0;
            fcnt      <= '0;
            fk        <= '0;
            cap_slot  <= '0;
            rd_pend   <= 1'b0;
            beat_data <= '0;
            beat_keep <= '0;
            beat_last <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if (rd_en) begin
                idx      <= idx + 11'd1;
                fcnt     <= fcnt + 3'd1;
                cap_slot <= fcnt[1:0];
            end
            case (state)
                S_IDLE: if (req_compl) begin
                    base_dw  <= req_addr[31:2];
                    first_be <= req_be[3:0];
                    last_be  <= req_be[7:4];
                    len_dw   <= req_l;
                    idx      <= '0;
                    if (!req_compl_wd || req_ur) begin
                        beat_data <= {32'h0, dw2_c, dw1_c, dw0_c};
                        beat_keep <= 16'h0FFF;
                        beat_last <= 1'b1;
                        remaining <= '0;
                    end else begin
                        beat_data <= {32'h0, dw2_d, dw1_d, dw0_d};
                        beat_keep <= 16'hFFFF;
                        beat_last <= (req_l == 11'd1);
                        remaining <= req_l - 11'd1;
                    end
                end
                S_HDR_LOAD: beat_data[127:96] <= rd_data;
                S_FETCH: if (rd_pend) beat_data[{cap_slot, 5'b0} +: 32] <= rd_data;
                S_SEND: if (s_axis_tx_tready && remaining != 11'd0) begin
                    remaining <= remaining - {8'd0, chunk};
                    fk        <= chunk;
                    fcnt      <= '0;
                    beat_data <= '0;
                    beat_keep <= keep_of(chunk);
                    beat_last <= (remaining == {8'd0, chunk});
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        rd_en            = (state == S_HDR_FETCH) || ((state == S_FETCH) && (fcnt < fk));
        rd_addr          = {base_dw + {19'd0, idx}, 2'b00};
        if (idx == 11'd0)                 rd_be = first_be;
        else if (idx == len_dw - 11'd1)   rd_be = last_be;
        else                              rd_be = 4'hF;
        s_axis_tx_tvalid = (state == S_SEND) || (state == S_CPL);
        s_axis_tx_tlast  = s_axis_tx_tvalid && beat_last;
        compl_done       = s_axis_tx_tvalid && s_axis_tx_tready && beat_last;
        s_axis_tx_tdata  = beat_data;
        s_axis_tx_tkeep  = beat_keep;
        tx_src_dsc       = 1'b0;
    end

endmodule

// File: tb/tb_pcie_cpl_tx_multi.sv
// tb/tb_pcie_cpl_tx_multi.sv - scoreboard bench for pcie_cpl_tx_multi
module tb_pcie_cpl_tx_multi;

    localparam logic [15:0] CID = 16'h01A0;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         s_axis_tx_tready = 1'b1;
    logic [127:0] s_axis_tx_tdata;
    logic [15:0]  s_axis_tx_tkeep;
    logic         s_axis_tx_tlast, s_axis_tx_tvalid, tx_src_dsc;
    logic         req_compl = 1'b0, req_compl_wd = 1'b0, req_td = 1'b0, req_ep = 1'b0;
    logic [2:0]   req_tc = '0;
    logic [1:0]   req_attr = '0;
    logic [9:0]   req_len = '0;
    logic [15:0]  req_rid = '0;
    logic [7:0]   req_tag = '0, req_be = '0;
    logic [31:0]  req_addr = '0;
    logic         rd_en, compl_done;
    logic [31:0]  rd_addr, rd_data = '0;
    logic [3:0]   rd_be;

    always #5 i_clk = ~i_clk;

    pcie_cpl_tx_multi #(.P_DATA_WIDTH(128), .P_MAX_LEN_DW(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .s_axis_tx_tready(s_axis_tx_tready), .s_axis_tx_tdata(s_axis_tx_tdata),
        .s_axis_tx_tkeep(s_axis_tx_tkeep), .s_axis_tx_tlast(s_axis_tx_tlast),
        .s_axis_tx_tvalid(s_axis_tx_tvalid), .tx_src_dsc(tx_src_dsc),
        .req_compl(req_compl), .req_compl_wd(req_compl_wd), .req_tc(req_tc),
        .req_td(req_td), .req_ep(req_ep), .req_attr(req_attr), .req_len(req_len),
        .req_rid(req_rid), .req_tag(req_tag), .req_be(req_be), .req_addr(req_addr),
        .completer_id(CID), .rd_en(rd_en), .rd_addr(rd_addr), .rd_be(rd_be),
        .rd_data(rd_data), .compl_done(compl_done)
    );

    typedef struct packed { logic [127:0] d; logic [15:0] k; logic l; } beat_t;
    typedef struct packed { logic [31:0] a; logic [3:0] be; } rd_t;

    beat_t beat_q[$];
    rd_t   rd_q[$];
    int checks = 0, errors = 0, hs_cnt = 0, done_cnt = 0, exp_done = 0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h0000_1004) ? 32'hDEADBEEF : {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    function automatic int lsb(input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) return i;
        return 0;
    endfunction

    function automatic int msb(input logic [3:0] b);
        for (int i = 3; i >= 0; i--) if (b[i]) return i;
        return 0;
    endfunction

    function automatic logic [11:0] bc_one(input logic [3:0] b);
        return (b == 4'd0) ? 12'd1 : 12'(msb(b) - lsb(b) + 1);
    endfunction

    // Read responder: one cycle latency
    always @(posedge i_clk) if (rd_en) rd_data <= pat(rd_addr);

    // Monitor sampled away from the active edge
    logic         stall_prev = 1'b0;
    logic [127:0] pd;
    logic [15:0]  pk;
    logic         pl;
    always @(negedge i_clk) begin
        if (i_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (rd_en) begin
                checks++;
                assert (rd_q.size() != 0) else begin
                    errors++; $error("FAIL rd_extra: observed addr %h, expected no read", rd_addr);
                end
                if (rd_q.size() != 0) begin
                    rd_t e;
                    e = rd_q.pop_front();
                    checks++;
                    assert (rd_addr === e.a && rd_be === e.be) else begin
                        errors++; $error("FAIL rd_port: observed %h/%h expected %h/%h", rd_addr, rd_be, e.a, e.be);
                    end
                end
            end
            if (stall_prev) begin
                checks++;
                assert (s_axis_tx_tvalid === 1'b1 && s_axis_tx_tdata === pd &&
                        s_axis_tx_tkeep === pk && s_axis_tx_tlast === pl) else begin
                    errors++; $error("FAIL stall_hold: observed v%b %h %h l%b expected v1 %h %h l%b",
                                     s_axis_tx_tvalid, s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, pd, pk, pl);
                end
            end
            if (s_axis_tx_tvalid === 1'b1 && s_axis_tx_tready === 1'b1) begin
                hs_cnt++;
                checks++;
                assert (beat_q.size() != 0) else begin
                    errors++; $error("FAIL beat_extra: observed %h, expected no beat", s_axis_tx_tdata);
                end
                if (beat_q.size() != 0) begin
                    beat_t e;
                    e = beat_q.pop_front();
                    checks++;
                    assert (s_axis_tx_tdata === e.d && s_axis_tx_tkeep === e.k && s_axis_tx_tlast === e.l) else begin
                        errors++; $error("FAIL beat: observed %h %h l%b expected %h %h l%b",
                                         s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, e.d, e.k, e.l);
                    end
                end
            end
            checks++;
            assert (compl_done === (s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast)) else begin
                errors++; $error("FAIL compl_done: observed %b expected %b", compl_done,
                                 s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast);
            end
            if (compl_done === 1'b1) done_cnt++;
            stall_prev = (s_axis_tx_tvalid === 1'b1) && (s_axis_tx_tready !== 1'b1);
            pd = s_axis_tx_tdata; pk = s_axis_tx_tkeep; pl = s_axis_tx_tlast;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Push expectations for a request, then present it for one cycle
    task automatic do_req(input bit wd, input logic [9:0] len, input logic [7:0] be,
                          input logic [31:0] addr, input logic [2:0] tc, input logic [7:0] tag);
        int          l_dw, i, n;
        bit          ur;
        logic [3:0]  fb, lb;
        logic [11:0] bc;
        logic [6:0]  la;
        logic [31:0] dw0, dw1, dw2;
        logic [31:0] p[$];
        beat_t       b;
        rd_t         r;
        l_dw = (len == 10'd0) ? 1024 : int'(len);
        ur = wd && (l_dw > 32);
        fb = be[3:0];
        lb = be[7:4];
        if (!wd || ur) begin
            bc  = ur ? 12'd0 : bc_one(fb);
            dw0 = {1'b0, 7'b0001010, 1'b0, tc, 4'b0, tc[0], tc[1], tag[1:0], 2'b0, 10'd0};
            dw1 = {CID, (ur ? 3'b001 : 3'b000), 1'b0, bc};
            dw2 = {tag, ~tag, tag, 1'b0, 7'd0};
            b.d = {32'h0, dw2, dw1, dw0}; b.k = 16'h0FFF; b.l = 1'b1;
            beat_q.push_back(b);
        end else begin
            bc  = (l_dw == 1) ? bc_one(fb) : 12'(4 * l_dw - lsb(fb) - (3 - msb(lb)));
            la  = {addr[6:2], 2'(lsb(fb))};
            dw0 = {1'b0, 7'b1001010, 1'b0, tc, 4'b0, tc[0], tc[1], tag[1:0], 2'b0, len};
            dw1 = {CID, 3'b000, 1'b0, bc};
            dw2 = {tag, ~tag, tag, 1'b0, la};
            for (i = 0; i < l_dw; i++) begin
                r.a  = {addr[31:2] + 30'(i), 2'b00};
                r.be = (i == 0) ? fb : (i == l_dw - 1) ? lb : 4'hF;
                rd_q.push_back(r);
                p.push_back(pat(r.a));
            end
            b.d = {p[0], dw2, dw1, dw0}; b.k = 16'hFFFF; b.l = (l_dw == 1);
            beat_q.push_back(b);
            i = 1;
            while (i < l_dw) begin
                n = (l_dw - i > 4) ? 4 : l_dw - i;
                b.d = '0;
                for (int j = 0; j < n; j++) b.d[j*32 +: 32] = p[i + j];
                b.k = 16'((1 << (4 * n)) - 1);
                b.l = (i + n == l_dw);
                beat_q.push_back(b);
                i += n;
            end
        end
        exp_done++;
        req_compl_wd = wd; req_len = len; req_be = be; req_addr = addr;
        req_tc = tc; req_td = tc[0]; req_ep = tc[1]; req_attr = tag[1:0];
        req_tag = tag; req_rid = {tag, ~tag};
        req_compl = 1'b1;
        step();
        req_compl = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt < exp_done && n < 400) begin step(); n++; end
        step();
        checks++;
        assert (done_cnt === exp_done) else begin
            errors++; $error("FAIL %s: observed done count %0d expected %0d", tag, done_cnt, exp_done);
        end
        checks++;
        assert (beat_q.size() == 0 && rd_q.size() == 0) else begin
            errors++; $error("FAIL %s_drain: observed beats/reads left %0d/%0d expected 0/0", tag, beat_q.size(), rd_q.size());
        end
    endtask

    task automatic wait_hs(input int target, input string tag);
        int n = 0;
        while (hs_cnt < target && n < 100) begin step(); n++; end
        checks++;
        assert (hs_cnt >= target) else begin
            errors++; $error("FAIL %s: observed handshakes %0d expected %0d", tag, hs_cnt, target);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (s_axis_tx_tvalid !== 1'b1 && n < 100) begin step(); n++; end
        checks++;
        assert (s_axis_tx_tvalid === 1'b1) else begin
            errors++; $error("FAIL %s: observed tvalid %b expected 1", tag, s_axis_tx_tvalid);
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        assert (s_axis_tx_tvalid === 1'b0 && s_axis_tx_tlast === 1'b0 && compl_done === 1'b0 &&
                rd_en === 1'b0 && s_axis_tx_tdata === 128'd0 && s_axis_tx_tkeep === 16'd0 &&
                tx_src_dsc === 1'b0) else begin
            errors++; $error("FAIL %s: observed v%b l%b d%b r%b %h %h expected all zero", tag, s_axis_tx_tvalid,
                             s_axis_tx_tlast, compl_done, rd_en, s_axis_tx_tdata, s_axis_tx_tkeep);
        end
    endtask

    logic [9:0]  lens  [6] = '{10'd2, 10'd3, 10'd4, 10'd5, 10'd32, 10'd33};
    logic [31:0] addrs [6] = '{32'h0000_3008, 32'h0000_4010, 32'hFFFF_FFF8, 32'h0000_5000, 32'h0000_6044, 32'h0000_7000};

    initial begin
        i_rst = 1'b1;
        repeat (3) step();
        check_idle("reset_state");
        i_rst = 1'b0;
        step();

        // 1: single DW CplD
        do_req(1'b1, 10'd1, 8'h0F, 32'h0000_1004, 3'd0, 8'h11);
        wait_done("t1_l1");

        // 2: six DW, partial first/last BE
        do_req(1'b1, 10'd6, 8'h3E, 32'h0000_2000, 3'd5, 8'h22);
        wait_done("t2_l6");

        // 3: same, stalled three cycles on beat 1
        do_req(1'b1, 10'd6, 8'h3E, 32'h0000_2000, 3'd2, 8'h33);
        wait_hs(hs_cnt + 1, "t3_beat0");
        s_axis_tx_tready = 1'b0;
        wait_valid("t3_beat1");
        repeat (3) step();
        s_axis_tx_tready = 1'b1;
        wait_done("t3_stall");

        // 4: unsupported request, over-length and 1024 DW
        do_req(1'b1, 10'd40, 8'hFF, 32'h0000_8000, 3'd1, 8'h44);
        wait_done("t4_ur40");
        do_req(1'b1, 10'd0, 8'hFF, 32'h0000_9000, 3'd3, 8'h45);
        wait_done("t4_ur0");

        // 5: Cpl without data; a request presented during the stall is ignored
        s_axis_tx_tready = 1'b0;
        do_req(1'b0, 10'd1, 8'h06, 32'h0000_A000, 3'd4, 8'h55);
        req_compl = 1'b1; req_compl_wd = 1'b1; req_len = 10'd2;
        repeat (2) step();
        req_compl = 1'b0;
        s_axis_tx_tready = 1'b1;
        wait_done("t5_cpl");
        repeat (6) step();
        checks++;
        assert (done_cnt === exp_done) else begin
            errors++; $error("FAIL t5_ignored: observed done count %0d expected %0d", done_cnt, exp_done);
        end

        // 6: reset in the middle of beat 1 of a nine DW read
        do_req(1'b1, 10'd9, 8'hFF, 32'h0000_B000, 3'd0, 8'h66);
        exp_done--;
        wait_hs(hs_cnt + 1, "t6_beat0");
        s_axis_tx_tready = 1'b0;
        wait_valid("t6_beat1");
        i_rst = 1'b1;
        beat_q.delete();
        rd_q.delete();
        step();
        check_idle("t6_after_rst");
        i_rst = 1'b0;
        s_axis_tx_tready = 1'b1;
        step();
        checks++;
        assert (done_cnt === exp_done) else begin
            errors++; $error("FAIL t6_no_done: observed done count %0d expected %0d", done_cnt, exp_done);
        end
        do_req(1'b1, 10'd1, 8'h0C, 32'h0000_C00C, 3'd6, 8'h67);
        wait_done("t6_recover");

        // Length sweep including the maximum, one past it, and address wrap
        for (int t = 0; t < 6; t++) begin
            do_req(1'b1, lens[t], 8'h1C, addrs[t], 3'(t), 8'(8'h70 + t));
            wait_done("sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_cpl_tx_multi.md
Name: pcie_cpl_tx_multi

Overview:
Parametrised successor to the single-DW PIO completion generator. Builds a PCIe Completion TLP on the 128-bit AXI-Stream TX interface for memory reads of 1..P_MAX_LEN_DW dwords, fetching payload from a 1-cycle-latency read port. Returns Unsupported Request (UR) status for over-length reads. Sits between the RX request decoder (req_* inputs) and the PCIe core TX port.

Parameters:
P_DATA_WIDTH, 128, AXIS data width; only 128 is supported.
P_KEEP_WIDTH, P_DATA_WIDTH/8, AXIS keep width.
P_MAX_LEN_DW, 32, largest read length in DW served with data (1..1024).

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
s_axis_tx_tready  in  1  core ready
s_axis_tx_tdata  out  128  TLP data, DW0 in [31:0]
s_axis_tx_tkeep  out  16  byte enables
s_axis_tx_tlast  out  1  last beat
s_axis_tx_tvalid  out  1  beat valid
tx_src_dsc  out  1  tied 0
req_compl  in  1  request pulse/level, sampled in IDLE only
req_compl_wd  in  1  1 = CplD, 0 = Cpl without data
req_tc  in  3  traffic class
req_td  in  1  TD bit
req_ep  in  1  EP bit
req_attr  in  2  attributes
req_len  in  10  length in DW (0 encodes 1024)
req_rid  in  16  requester ID
req_tag  in  8  tag
req_be  in  8  {last_be, first_be}
req_addr  in  32  byte address
completer_id  in  16  completer ID
rd_en  out  1  payload read strobe
rd_addr  out  32  DW-aligned byte address of read
rd_be  out  4  byte enables of read
rd_data  in  32  read data, valid the cycle after rd_en
compl_done  out  1  one-cycle pulse at final beat handshake

Behaviour:
- Reset: state IDLE; tvalid, tlast, compl_done, rd_en = 0; tdata, tkeep = 0. Reset mid-TLP aborts immediately, with no partial beat held.
- Request is latched in IDLE when req_compl = 1. req_compl outside IDLE is ignored.
- Length: L = (req_len == 0) ? 1024 : req_len.
- UR case: req_compl_wd = 1 and L > P_MAX_LEN_DW.
- Header format:
  - DW0 = {0, fmt_type, 0, tc, 4'b0, td, ep, attr, 2'b0, len}.
  - DW1 = {completer_id, status[2:0], bcm = 0, byte_count[11:0]}.
  - DW2 = {rid, tag, 0, lower_addr[6:0]}.
- CplD: fmt_type 7'b1001010, status 000, len = req_len.
- Cpl (req_compl_wd = 0) or UR: fmt_type 7'b0001010, len 0, single beat.
  - tkeep 0x0FFF, tlast = 1, DW3 = 0.
  - UR: status 001, byte_count 0, lower_addr 0.
  - Plain Cpl: status 000, byte_count from the first_be table, lower_addr 0.
- byte_count rule:
  - L == 1: first_be table. 1xx1 → 4; 01x1 or 1x10 → 3; 0011, 0110, 1100 → 2; single bit or 0000 → 1.
  - L > 1: 4·L − (trailing zeros of first_be) − (leading zeros of last_be); result is 12 bits, 1024 DW → 0 by wrap.
- lower_addr = {req_addr[6:2], offset of lowest set bit of first_be}; first_be = 0 gives 00.
- Beat plan:
  - Beat 0 carries DW0..DW2 + payload DW0, tkeep 0xFFFF.
  - Each further beat carries up to 4 payload DW, packed from DW0 upward. tkeep for n DW: 1 → 0x000F, 2 → 0x00FF, 3 → 0x0FFF, 4 → 0xFFFF.
  - Total beats = 1 + ceil((L − 1)/4). tlast only on the final beat.
- FSM:
  - IDLE: on req_compl, go to HDR_FETCH (CplD ok), or CPL (no data / UR).
  - HDR_FETCH: one rd_en, then HDR_LOAD.
  - HDR_LOAD: capture rd_data, then SEND.
  - FETCH: issue k = min(4, remaining) reads on consecutive cycles, capture each the next cycle, then SEND.
  - SEND: tvalid = 1, tdata/tkeep/tlast stable until tready. On handshake: remaining > 0 → FETCH; otherwise compl_done pulse and go to IDLE.
  - CPL: same as SEND with a single beat.
- Read port: rd_addr = {req_addr[31:2] + i, 2'b00} for payload index i, wrapping modulo 2^30.
  - rd_be = first_be for i = 0, last_be for i = L−1, 4'hF otherwise; L = 1 uses first_be.
- tvalid is never deasserted without a handshake. No new request is accepted until compl_done.

Test Plan:
1. CplD L = 1, be = 0x0F, addr 0x1004, rd_data 0xDEADBEEF, tready = 1 → one beat: DW3 = 0xDEADBEEF, byte_count 4, lower_addr 0x04, tkeep 0xFFFF, tlast = 1, compl_done pulse.
2. CplD L = 6, first_be 0xE, last_be 0x3, addr 0x2000 → byte_count 21, lower_addr 0x01. Three beats: tkeep FFFF, FFFF, 000F. rd_addr 0x2000..0x2014 with rd_be E, F, F, F, F, 3.
3. Scenario 2 with tready held low 3 cycles on beat 1 → tdata, tkeep, tlast unchanged during the stall; no extra rd_en; beat order intact.
4. req_len = 40 (> 32), req_compl_wd = 1 → single Cpl beat: status 001, len 0, byte_count 0, tkeep 0x0FFF, no rd_en. req_len = 0 also returns UR.
5. req_compl_wd = 0, be = 0x06 → Cpl: status 000, byte_count 2, tkeep 0x0FFF. A second req_compl asserted during SEND is ignored.
6. i_rst asserted mid-beat 1 of an L = 9 request → next cycle tvalid = 0, state IDLE, no compl_done. A following L = 1 request completes normally.
